// File: rtl/combo_sender_pkg.sv
// Shared types and constants for the combination sender and its code store.
package combo_sender_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned WAIT_W      = 3;
  localparam int unsigned DEFAULT_LEN = 6;

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  // Power-on combination 7,0,3,2,6,2; slot 0 sits in the least significant nibble.
  localparam logic [DEFAULT_LEN*DIGIT_W-1:0] DEFAULT_CODE =
    {4'd2, 4'd6, 4'd2, 4'd3, 4'd0, 4'd7};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Reset value of a code slot; slots beyond the default length reset to 0.
  function automatic logic [DIGIT_W-1:0] default_digit(input int unsigned slot);
    if (slot < DEFAULT_LEN) begin
      return DEFAULT_CODE[slot*DIGIT_W +: DIGIT_W];
    end
    return '0;
  endfunction

endpackage

// File: rtl/combo_code_store.sv
// Combination register file with load validation and a write-forwarding read port.
module combo_code_store
  import combo_sender_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load_en,
  input  logic [IDX_W-1:0]   i_load_idx,
  input  logic [DIGIT_W-1:0] i_load_digit,
  input  logic               i_wr_allow,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [DIGIT_W-1:0] o_rd_digit,
  output logic               o_load_err
);

  logic [DIGIT_W-1:0] r_code [NUM_DIGITS];
  logic               r_load_err;
  logic               w_wr_ok;
  logic [DIGIT_W-1:0] w_rd_mem;

  assign w_wr_ok = i_load_en && i_wr_allow && (i_load_digit <= MAX_DIGIT) &&
                   (32'(i_load_idx) < NUM_DIGITS);

  // Read port forwards a same-cycle write so a start alongside a load sees the new digit.
  assign w_rd_mem   = (32'(i_rd_idx) < NUM_DIGITS) ? r_code[i_rd_idx] : '0;
  assign o_rd_digit = (w_wr_ok && (i_load_idx == i_rd_idx)) ? i_load_digit : w_rd_mem;
  assign o_load_err = r_load_err;

  // Code slots: restore default on reset, accept only validated loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_code[i] <= default_digit(i);
      end
    end else if (w_wr_ok) begin
      r_code[i_load_idx] <= i_load_digit;
    end
  end

  // One-cycle error pulse for any rejected load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= i_load_en && !w_wr_ok;
    end
  end

endmodule

// File: rtl/combo_sender.sv
// Sends the stored combination to a lock over a valid/ready link and records the verdict.
module combo_sender
  import combo_sender_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned TIMEOUT_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               start,
  input  logic               abort,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               digit_valid,
  input  logic               digit_ready,
  input  logic               lock_open,
  input  logic               lock_closed,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic               load_err
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_index;
  logic [WAIT_W-1:0]  r_wait;
  logic [DIGIT_W-1:0] r_digit_out;
  logic               r_digit_valid;
  logic               r_busy;
  logic               r_pass;
  logic               r_fail;
  logic               r_timeout;

  logic               w_wr_allow;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [DIGIT_W-1:0] w_rd_digit;
  logic               w_xfer;
  logic               w_last;
  logic               w_wait_hit;

  assign w_wr_allow = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // Look one slot ahead while sending; slot 0 is fetched for the start edge.
  assign w_rd_idx   = (r_state == ST_SEND) ? (r_index + IDX_W'(1)) : '0;
  assign w_xfer     = r_digit_valid && digit_ready;
  assign w_last     = (r_index == IDX_W'(NUM_DIGITS - 1));
  assign w_wait_hit = (r_wait == WAIT_W'(TIMEOUT_CYC - 1));

  combo_code_store #(.NUM_DIGITS(NUM_DIGITS)) u_store (
    .clk          (clk),
    .reset        (reset),
    .i_load_en    (load_en),
    .i_load_idx   (load_idx),
    .i_load_digit (load_digit),
    .i_wr_allow   (w_wr_allow),
    .i_rd_idx     (w_rd_idx),
    .o_rd_digit   (w_rd_digit),
    .o_load_err   (load_err)
  );

  // Sequencer: state, counters and registered outputs; abort outranks handshake and verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_wait        <= '0;
      r_digit_out   <= '0;
      r_digit_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state       <= ST_SEND;
            r_index       <= '0;
            r_digit_out   <= w_rd_digit;
            r_digit_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
          end
        end
        ST_SEND: begin
          if (abort) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_digit_out   <= '0;
            r_digit_valid <= 1'b0;
            r_busy        <= 1'b0;
          end else if (w_xfer) begin
            if (w_last) begin
              r_state       <= ST_WAIT_RES;
              r_index       <= '0;
              r_wait        <= '0;
              r_digit_out   <= '0;
              r_digit_valid <= 1'b0;
            end else begin
              r_index     <= r_index + IDX_W'(1);
              r_digit_out <= w_rd_digit;
            end
          end
        end
        ST_WAIT_RES: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_busy  <= 1'b0;
          end else if (lock_closed) begin
            r_state <= ST_DONE;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
          end else if (lock_open) begin
            r_state <= ST_DONE;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
          end else if (w_wait_hit) begin
            r_state   <= ST_DONE;
            r_wait    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign digit_out   = r_digit_out;
  assign digit_valid = r_digit_valid;
  assign busy        = r_busy;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_combo_sender.sv
// Directed table-driven bench for combo_sender.
module tb_combo_sender;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic [2:0] load_idx;
  logic [3:0] load_digit;
  logic       start;
  logic       abort;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       digit_ready;
  logic       lock_open;
  logic       lock_closed;
  logic       busy;
  logic       pass;
  logic       fail;
  logic       timeout;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  combo_sender #(.NUM_DIGITS(6), .TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .load_digit  (load_digit),
    .start       (start),
    .abort       (abort),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .lock_open   (lock_open),
    .lock_closed (lock_closed),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .load_err    (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic       st, rdy, lo, lc, ab, le;
    logic [2:0] li;
    logic [3:0] ld;
    logic       v;
    logic [3:0] o;
    logic       b, p, f, t, e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, rdy, lo, lc, ab, le, input logic [2:0] li,
                     input logic [3:0] ld, input logic v, input logic [3:0] o,
                     input logic b, p, f, t, e);
    vec_t x;
    x.st = st; x.rdy = rdy; x.lo = lo; x.lc = lc; x.ab = ab; x.le = le;
    x.li = li; x.ld = ld; x.v = v; x.o = o; x.b = b; x.p = p; x.f = f;
    x.t = t; x.e = e;
    vecs.push_back(x);
  endtask

  function automatic logic [9:0] outs();
    return {digit_valid, digit_out, busy, pass, fail, timeout, load_err};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,out,busy,p,f,t,err}=%b_%h_%b%b%b%b%b required %b_%h_%b%b%b%b%b",
               name, outs()[9], outs()[8:5], outs()[4], outs()[3], outs()[2], outs()[1], outs()[0],
               exp[9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; load_en = 0; load_idx = 0; load_digit = 0;
    digit_ready = 0; lock_open = 0; lock_closed = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    check("reset_state", 10'b0);
    reset = 1'b0;
    step();

    //   st r lo lc ab le li ld   v  o  b p f t e
    // Default code streamed with ready held; lock_open in SEND ignored; pass later.
    add(1, 1, 0, 0, 0, 0, 0, 0,  1, 7, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0,  1, 6, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    // Stall on the third digit, start while busy ignored, both verdicts -> fail.
    add(1, 1, 0, 0, 0, 0, 0, 0,  1, 7, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 6, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    // Good load, bad digit, bad index, then a load during SEND; then timeout.
    add(0, 0, 0, 0, 0, 1, 3, 8,  0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 11, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 6, 1,  0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,  1, 7, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1,  1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 8, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 6, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    // Start with a same-cycle load of slot 0, abort after three digits.
    add(1, 0, 0, 0, 0, 1, 0, 5,  1, 5, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 8, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      start = vecs[i].st; digit_ready = vecs[i].rdy; lock_open = vecs[i].lo;
      lock_closed = vecs[i].lc; abort = vecs[i].ab; load_en = vecs[i].le;
      load_idx = vecs[i].li; load_digit = vecs[i].ld;
      step();
      check($sformatf("vec%0d", i),
            {vecs[i].v, vecs[i].o, vecs[i].b, vecs[i].p, vecs[i].f, vecs[i].t, vecs[i].e});
    end

    // Async reset in the middle of SEND clears outputs before any clock edge.
    idle_inputs();
    start = 1;
    step();
    check("send_before_reset", {1'b1, 4'd5, 5'b10000});
    start = 0;
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_mid_send", 10'b0);
    #1;
    reset = 1'b0;
    step();
    check("idle_after_reset", 10'b0);

    // Default code restored by reset.
    begin
      logic [3:0] exp_code [6];
      exp_code = '{4'd7, 4'd0, 4'd3, 4'd2, 4'd6, 4'd2};
      start = 1; digit_ready = 1;
      for (int k = 0; k < 6; k++) begin
        step();
        start = 0;
        check($sformatf("restored_digit%0d", k), {1'b1, exp_code[k], 5'b10000});
      end
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
